baud_gen: RTL and testbench

Parametrised baud-rate generator for the UART datapath. It turns the 4-bit baud select into a bit-period divisor and an oversampling divisor, computed from `CLK_HZ` at elaboration. It produces a one-bit-per-period `tx_tick` for the transmitter and `OVERSAMPLE` ticks per bit (`rx_tick`) plus a mid-bit strobe for the receiver. It sits between the baud-select register and the TX/RX engines, and replaces the fixed 100 MHz decoder table.

---
 rtl/baud_gen.sv | 179 +++++++++++++++++
 tb/tb_baud_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_gen.sv
// baud_gen -- parametrised baud-rate generator for the UART datapath.
//
// Both divisor tables are built from CLK_HZ at elaboration. A registered
// copy of the baud select chooses the active entries, so there is no
// runtime divider.
//
// Parameters
//   CLK_HZ      system clock frequency in Hz
//   OVERSAMPLE  RX ticks per bit (power of 2, >= 4)
//   CNT_W       counter / divisor width
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   baud_val    baud select code (0..11 = 300..921600 baud, 12..15 = 300)
//   enable      runs the counters; low holds them cleared
//   rx_restart  one-cycle realign of the RX oversample timebase
//   k           active TX divisor (clocks per bit)
//   tx_tick     one-cycle pulse per bit period
//   rx_tick     one-cycle pulse, OVERSAMPLE per bit period
//   rx_phase    number of rx_ticks already completed within the current bit
//   rx_mid      mid-bit strobe, coincident with an rx_tick
module baud_gen #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = 19
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [3:0]                    baud_val,
    input  logic                          enable,
    input  logic                          rx_restart,
    output logic [CNT_W-1:0]              k,
    output logic                          tx_tick,
    output logic                          rx_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] rx_phase,
    output logic                          rx_mid
);

    localparam int PH_W = $clog2(OVERSAMPLE);
    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    function automatic longint unsigned rate_of(input int code);
        case (code)
            1:       return 64'd1200;
            2:       return 64'd2400;
            3:       return 64'd4800;
            4:       return 64'd9600;
            5:       return 64'd19200;
            6:       return 64'd38400;
            7:       return 64'd57600;
            8:       return 64'd115200;
            9:       return 64'd230400;
            10:      return 64'd460800;
            11:      return 64'd921600;
            default: return 64'd300;
        endcase
    endfunction

    // Clocks per bit, rounded to nearest.
    function automatic longint unsigned tx_div(input int code);
        longint unsigned hz;
        longint unsigned r;
        hz = longint'(CLK_HZ);
        r  = rate_of(code);
        return (hz + r / 2) / r;
    endfunction

    // Clocks per oversample tick, rounded to nearest. The floor of 2 keeps
    // the wrap compare (count == kr-1) distinct from the cleared count.
    function automatic longint unsigned rx_div(input int code);
        longint unsigned hz;
        longint unsigned r;
        longint unsigned d;
        hz = longint'(CLK_HZ);
        r  = rate_of(code) * longint'(OVERSAMPLE);
        d  = (hz + r / 2) / r;
        if (d < 64'd2) begin
            d = 64'd2;
        end
        return d;
    endfunction

    // Code 0 (300 baud) always has the largest divisor.
    if (tx_div(0) > CNT_MAX) begin : g_bad_cnt_w
        $error("baud_gen: CNT_W too small for the 300 baud divisor");
    end

    if (OVERSAMPLE < 4 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_oversample
        $error("baud_gen: OVERSAMPLE must be a power of 2 and at least 4");
    end

    logic [CNT_W-1:0] k_tab  [16];
    logic [CNT_W-1:0] kr_tab [16];

    for (genvar i = 0; i < 16; i++) begin : g_tab
        assign k_tab[i]  = CNT_W'(tx_div(i));
        assign kr_tab[i] = CNT_W'(rx_div(i));
    end

    logic [3:0]       baud_reg;
    logic             started;
    logic [CNT_W-1:0] kr;
    logic [CNT_W-1:0] tx_cnt;
    logic [CNT_W-1:0] rx_cnt;

    logic             tx_clear;
    logic             rx_clear;
    logic [CNT_W-1:0] tx_next;
    logic [CNT_W-1:0] rx_next;
    logic [PH_W-1:0]  phase_next;
    logic             tx_tick_next;
    logic             rx_tick_next;
    logic             rx_mid_next;

    assign k  = k_tab[baud_reg];
    assign kr = kr_tab[baud_reg];

    // Next-state for both timebases. 'started' is low on the first enabled
    // edge after a hold or reset, so that edge is itself a clearing edge and
    // the first tick lands exactly k cycles later. Pulses are registered from
    // the next count, which keeps every output free of input paths and lets a
    // clearing edge suppress the pulse it would otherwise have raised.
    always_comb begin
        tx_clear     = 1'b0;
        rx_clear     = 1'b0;
        tx_next      = '0;
        rx_next      = '0;
        phase_next   = '0;
        tx_tick_next = 1'b0;
        rx_tick_next = 1'b0;
        rx_mid_next  = 1'b0;

        tx_clear = !enable || !started || (baud_val != baud_reg);
        rx_clear = tx_clear || rx_restart;

        if (!tx_clear && tx_cnt != k - 1'b1) begin
            tx_next = tx_cnt + 1'b1;
        end

        if (!rx_clear) begin
            if (rx_cnt == kr - 1'b1) begin
                phase_next = rx_phase + 1'b1;
            end else begin
                rx_next    = rx_cnt + 1'b1;
                phase_next = rx_phase;
            end
        end

        tx_tick_next = !tx_clear && (tx_next == k - 1'b1);
        rx_tick_next = !rx_clear && (rx_next == kr - 1'b1);
        rx_mid_next  = rx_tick_next && (phase_next == PH_W'(OVERSAMPLE / 2 - 1));
    end

    // State register. baud_reg follows baud_val every cycle regardless of
    // enable so that k always reflects the selected rate.
    always_ff @(posedge clk) begin
        if (reset) begin
            baud_reg <= '0;
            started  <= 1'b0;
            tx_cnt   <= '0;
            rx_cnt   <= '0;
            rx_phase <= '0;
            tx_tick  <= 1'b0;
            rx_tick  <= 1'b0;
            rx_mid   <= 1'b0;
        end else begin
            baud_reg <= baud_val;
            started  <= enable;
            tx_cnt   <= tx_next;
            rx_cnt   <= rx_next;
            rx_phase <= phase_next;
            tx_tick  <= tx_tick_next;
            rx_tick  <= rx_tick_next;
            rx_mid   <= rx_mid_next;
        end
    end

endmodule

// File: tb/tb_baud_gen.sv
// tb_baud_gen -- self-checking bench for baud_gen at 100 MHz, OVERSAMPLE 16.
//
// A cycle model derives every output from the number of edges since the
// last clearing edge of each timebase; a compare process checks it against
// the DUT on every negedge. Directed sequences add literal expectations for
// divisors and tick spacing.
module tb_baud_gen;

    localparam int CLK_HZ = 100_000_000;
    localparam int OS     = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  baud_val;
    logic        enable;
    logic        rx_restart;
    logic [18:0] k;
    logic        tx_tick;
    logic        rx_tick;
    logic [3:0]  rx_phase;
    logic        rx_mid;

    int checks = 0;
    int errors = 0;

    baud_gen #(
        .CLK_HZ(CLK_HZ),
        .OVERSAMPLE(OS),
        .CNT_W(19)
    ) dut (
        .clk(clk),
        .reset(reset),
        .baud_val(baud_val),
        .enable(enable),
        .rx_restart(rx_restart),
        .k(k),
        .tx_tick(tx_tick),
        .rx_tick(rx_tick),
        .rx_phase(rx_phase),
        .rx_mid(rx_mid)
    );

    always #5 clk = ~clk;

    // Published divisors at 100 MHz; codes 12..15 fall back to 300 baud.
    longint expKTab [16] = '{333333, 83333, 41667, 20833, 10417, 5208, 2604,
                             1736, 868, 434, 217, 109,
                             333333, 333333, 333333, 333333};

    longint rates [12] = '{300, 1200, 2400, 4800, 9600, 19200, 38400, 57600,
                           115200, 230400, 460800, 921600};

    function automatic longint rateOf(input int code);
        return (code < 12) ? rates[code] : 64'd300;
    endfunction

    function automatic longint kOf(input int code);
        longint r = rateOf(code);
        return (longint'(CLK_HZ) + r / 2) / r;
    endfunction

    function automatic longint krOf(input int code);
        longint r = rateOf(code) * OS;
        longint d = (longint'(CLK_HZ) + r / 2) / r;
        return (d < 2) ? 64'd2 : d;
    endfunction

    // Cycle model: outputs follow from edges elapsed since the last clear.
    longint      cycleN = 0;
    longint      lastTx = 0;
    longint      lastRx = 0;
    int          baudM = 0;
    bit          prevEn = 1'b0;
    bit          modelValid = 1'b0;
    bit          txClr;
    bit          rxClr;
    longint      kM;
    longint      krM;
    longint      txSince;
    longint      rxSince;
    logic [18:0] expK;
    logic        expTx;
    logic        expRx;
    logic [3:0]  expPhase;
    logic        expMid;

    initial forever begin
        @(posedge clk);
        cycleN++;
        if (reset) begin
            baudM  = 0;
            prevEn = 1'b0;
            lastTx = cycleN;
            lastRx = cycleN;
        end else begin
            txClr  = !enable || !prevEn || (int'(baud_val) != baudM);
            rxClr  = txClr || rx_restart;
            baudM  = int'(baud_val);
            prevEn = enable;
            if (txClr) lastTx = cycleN;
            if (rxClr) lastRx = cycleN;
        end
        kM       = kOf(baudM);
        krM      = krOf(baudM);
        txSince  = cycleN - lastTx;
        rxSince  = cycleN - lastRx;
        expK     = 19'(kM);
        expTx    = (txSince % kM) == kM - 1;
        expRx    = (rxSince % krM) == krM - 1;
        expPhase = 4'((rxSince / krM) % OS);
        expMid   = expRx && (((rxSince / krM) % OS) == OS / 2 - 1);
        modelValid = 1'b1;
    end

    // Compare the DUT against the model every cycle, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (modelValid) begin
            checks++;
            if ({k, tx_tick, rx_tick, rx_phase, rx_mid} !==
                {expK, expTx, expRx, expPhase, expMid}) begin
                errors++;
                $display("[TB] FAIL cycle model @%0d: got k=%0d tx=%b rx=%b ph=%0d mid=%b, want k=%0d tx=%b rx=%b ph=%0d mid=%b",
                         cycleN, k, tx_tick, rx_tick, rx_phase, rx_mid,
                         expK, expTx, expRx, expPhase, expMid);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] baud, input logic en,
                                 input logic restart);
        baud_val   = baud;
        enable     = en;
        rx_restart = restart;
    endtask

    // Counts negedges until the selected pulse is seen (0 tx, 1 rx, 2 mid).
    // Called at the negedge before the edge of interest, so a pulse rising
    // n edges later returns n.
    task automatic waitPulse(input int sel, output longint cyc);
        bit seen;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            seen = (sel == 0) ? tx_tick : (sel == 1) ? rx_tick : rx_mid;
        end
        if (!seen) begin
            errors++;
            $display("[TB] FAIL pulse timeout: select %0d not seen in %0d cycles", sel, cyc);
        end
    endtask

    longint cyc;
    int     pulses;

    initial begin
        // Pin the model tables to the published values.
        for (int i = 0; i < 12; i++) begin
            checkOutput($sformatf("model k code %0d", i), kOf(i), expKTab[i]);
        end
        checkOutput("model kr 9600", krOf(4), 651);
        checkOutput("model kr 115200", krOf(8), 54);
        checkOutput("model kr 921600", krOf(11), 7);

        // Reset with code 4 already selected.
        reset = 1'b1;
        applyStimulus(4'd4, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("reset k", k, 333333);
        checkOutput("reset tx_tick", tx_tick, 0);
        checkOutput("reset rx_tick", rx_tick, 0);
        checkOutput("reset rx_phase", rx_phase, 0);
        checkOutput("reset rx_mid", rx_mid, 0);
        reset = 1'b0;
        checkOutput("k before update", k, 333333);
        waitPulse(0, cyc);
        checkOutput("9600 first tx", cyc, 10417);
        checkOutput("9600 k", k, 10417);
        waitPulse(0, cyc);
        checkOutput("9600 tx period", cyc, 10417);

        // Every code decodes to its divisor one edge after selection.
        for (int c = 0; c < 16; c++) begin
            applyStimulus(4'(c), 1'b1, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("k code %0d", c), k, expKTab[c]);
        end

        // Fastest rate: mid-bit strobe, then tick spacing.
        applyStimulus(4'd11, 1'b1, 1'b0);
        waitPulse(2, cyc);
        checkOutput("921600 first mid", cyc, 56);
        waitPulse(2, cyc);
        checkOutput("921600 mid period", cyc, 112);
        applyStimulus(4'd10, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(4'd11, 1'b1, 1'b0);
        waitPulse(1, cyc);
        checkOutput("921600 first rx", cyc, 7);
        waitPulse(1, cyc);
        checkOutput("921600 rx period", cyc, 7);
        waitPulse(0, cyc);
        checkOutput("921600 first tx after rx", cyc, 109 - 14);
        waitPulse(0, cyc);
        checkOutput("921600 tx period", cyc, 109);

        // Rate change mid-count restarts the TX timebase.
        applyStimulus(4'd8, 1'b1, 1'b0);
        repeat (400) @(negedge clk);
        applyStimulus(4'd9, 1'b1, 1'b0);
        waitPulse(0, cyc);
        checkOutput("8 to 9 first tx", cyc, 434);

        // rx_restart landing on the third rx_tick edge at 115200.
        applyStimulus(4'd8, 1'b1, 1'b0);
        repeat (161) @(negedge clk);
        checkOutput("phase before restart", rx_phase, 2);
        applyStimulus(4'd8, 1'b1, 1'b1);
        @(negedge clk);
        applyStimulus(4'd8, 1'b1, 1'b0);
        checkOutput("restart suppresses rx", rx_tick, 0);
        checkOutput("restart clears phase", rx_phase, 0);
        waitPulse(1, cyc);
        checkOutput("rx after restart", cyc, 53);
        waitPulse(0, cyc);
        checkOutput("tx unaffected by restart", cyc, 868 - 215);
        waitPulse(0, cyc);
        checkOutput("115200 tx period", cyc, 868);

        // Hold for 100 cycles, with a restart pulse inside the hold.
        applyStimulus(4'd8, 1'b0, 1'b0);
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            pulses += int'(tx_tick) + int'(rx_tick) + int'(rx_mid);
            applyStimulus(4'd8, 1'b0, (i == 50) ? 1'b1 : 1'b0);
        end
        checkOutput("pulses while disabled", pulses, 0);
        checkOutput("phase while disabled", rx_phase, 0);
        applyStimulus(4'd8, 1'b1, 1'b0);
        waitPulse(0, cyc);
        checkOutput("tx after re-enable", cyc, 868);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
